// File: rtl/fb_pkg.sv
// Shared types for the multi-bank frame buffer: bank indices, role record and clear-sweep states.
package fb_pkg;

  typedef logic [1:0] buf_idx_t;

  // In 3-bank mode the spare slot doubles as the ready slot while ready_vld is set.
  // In 2-bank mode ready_vld is the pending-swap flag.
  typedef struct packed {
    buf_idx_t front;
    buf_idx_t back;
    buf_idx_t spare;
    logic     ready_vld;
  } roles_t;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_t;

  localparam roles_t RESET_ROLES = '{front: 2'd0, back: 2'd1, spare: 2'd2, ready_vld: 1'b0};

  function automatic bit num_bufs_legal(input int n);
    return (n == 2) || (n == 3);
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame-buffer bank: simple dual-port RAM with synchronous write and registered read.
module fb_bank #(
  parameter int PIXEL_W = 1,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/frame_buffer_multi.sv
// 2- or 3-bank tear-free frame buffer with vsync-deferred swaps.
// Optional hardware clear of each new back bank is enabled by defining FB_CLEAR_EN.
module frame_buffer_multi
  import fb_pkg::*;
#(
  parameter int                 PIXEL_W   = 1,
  parameter int                 ADDR_W    = 19,
  parameter int                 DEPTH     = 307200,
  parameter int                 NUM_BUFS  = 2,
  parameter logic [PIXEL_W-1:0] CLEAR_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               swap,
  input  logic               vsync,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               swap_pending,
  output logic               swap_done,
  output logic               clear_busy
);

  localparam int              BANK_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam bit              TWO_BANK  = (NUM_BUFS == 2);

  if (!num_bufs_legal(NUM_BUFS)) begin : g_bad_num_bufs
    $error("frame_buffer_multi: NUM_BUFS must be 2 or 3");
  end

  roles_t             roles, n_roles;
  clr_state_t         clr_state;
  logic [BANK_AW-1:0] clr_addr;
  logic               n_clr_busy;
  logic               n_swap_done;
  logic               swap_ok;
  logic               sweeping;
  buf_idx_t           front_d;
  logic               rd_vld_d;
  logic               wr_in_range, rd_in_range, wr_go;
  logic [BANK_AW-1:0] bank_waddr;
  logic [PIXEL_W-1:0] bank_wdata;
  logic [NUM_BUFS-1:0] bank_we;
  logic [PIXEL_W-1:0] bank_q [NUM_BUFS];

  assign sweeping    = (clr_state == CLR_SWEEP);
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_LIM;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_LIM;

  // Role transitions; a swap arriving while the new back bank is being cleared is ignored.
  always_comb begin
    n_roles     = roles;
    n_swap_done = 1'b0;
    swap_ok     = swap && !sweeping;
    if (TWO_BANK) begin
      if (vsync && roles.ready_vld) begin
        n_roles.front     = roles.back;
        n_roles.back      = roles.front;
        n_roles.ready_vld = 1'b0;
        n_swap_done       = 1'b1;
      end else if (swap_ok && !roles.ready_vld) begin
        n_roles.ready_vld = 1'b1;
      end
    end else begin
      if (vsync && roles.ready_vld) begin
        n_swap_done   = 1'b1;
        n_roles.front = roles.spare;
        if (swap_ok) begin
          n_roles.spare = roles.back;
          n_roles.back  = roles.front;
        end else begin
          n_roles.spare     = roles.front;
          n_roles.ready_vld = 1'b0;
        end
      end else if (swap_ok) begin
        n_roles.back      = roles.spare;
        n_roles.spare     = roles.back;
        n_roles.ready_vld = 1'b1;
      end
    end
  end

`ifdef FB_CLEAR_EN
  localparam logic [BANK_AW-1:0] LAST_ADDR = BANK_AW'(DEPTH - 1);
  logic new_back;

  // Every fresh back assignment (re)starts the sweep from address 0 on that bank.
  assign new_back   = (n_roles.back != roles.back);
  assign n_clr_busy = new_back || (sweeping && clr_addr != LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
    end else if (ce) begin
      if (new_back) begin
        clr_state <= CLR_SWEEP;
        clr_addr  <= '0;
      end else if (sweeping) begin
        if (clr_addr == LAST_ADDR) clr_state <= CLR_IDLE;
        else clr_addr <= clr_addr + 1'b1;
      end
    end
  end
`else
  assign clr_state  = CLR_IDLE;
  assign clr_addr   = '0;
  assign n_clr_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      roles     <= RESET_ROLES;
      swap_done <= 1'b0;
      wr_ready  <= 1'b1;
      front_d   <= '0;
      rd_vld_d  <= 1'b0;
    end else if (ce) begin
      roles     <= n_roles;
      swap_done <= n_swap_done;
      wr_ready  <= !(TWO_BANK && n_roles.ready_vld) && !n_clr_busy;
      front_d   <= roles.front;
      rd_vld_d  <= rd_in_range;
    end
  end

  assign swap_pending = roles.ready_vld;
  assign clear_busy   = sweeping;

  assign wr_go      = sweeping || (wr_en && wr_ready && wr_in_range);
  assign bank_waddr = sweeping ? clr_addr : wr_addr[BANK_AW-1:0];
  assign bank_wdata = sweeping ? CLEAR_VAL : wr_data;

  for (genvar b = 0; b < NUM_BUFS; b++) begin : g_bank
    assign bank_we[b] = ce && wr_go && (roles.back == buf_idx_t'(b));

    fb_bank #(
      .PIXEL_W (PIXEL_W),
      .DEPTH   (DEPTH),
      .AW      (BANK_AW)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we[b]),
      .wr_addr (bank_waddr),
      .wr_data (bank_wdata),
      .rd_en   (ce),
      .rd_addr (rd_addr[BANK_AW-1:0]),
      .rd_data (bank_q[b])
    );
  end

  // Bank select follows the front index of the cycle the address was issued in.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < NUM_BUFS; b++) begin
      if (rd_vld_d && front_d == buf_idx_t'(b)) rd_data = bank_q[b];
    end
  end

endmodule

// File: tb/tb_frame_buffer_multi.sv
// Directed bench for frame_buffer_multi: one 2-bank and one 3-bank instance on a shared clock.
module tb_frame_buffer_multi;

  logic       clk = 1'b0;
  logic       rst, ce;
  logic       swap2, vsync2, wr_en2;
  logic       swap3, vsync3, wr_en3;
  logic [4:0] wr_addr, rd_addr;
  logic [3:0] wr_data;
  logic       wr_ready2, swap_pending2, swap_done2, clear_busy2;
  logic       wr_ready3, swap_pending3, swap_done3, clear_busy3;
  logic [3:0] rd_data2, rd_data3;
  int         checks = 0;
  int         errors = 0;
  logic       u3_low_seen = 1'b0;

  always #5 clk = ~clk;

  frame_buffer_multi #(.PIXEL_W(4), .ADDR_W(5), .DEPTH(16), .NUM_BUFS(2), .CLEAR_VAL(4'h6)) u2 (
    .clk(clk), .rst(rst), .ce(ce), .swap(swap2), .vsync(vsync2), .wr_en(wr_en2),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready2), .rd_addr(rd_addr),
    .rd_data(rd_data2), .swap_pending(swap_pending2), .swap_done(swap_done2),
    .clear_busy(clear_busy2)
  );

  frame_buffer_multi #(.PIXEL_W(4), .ADDR_W(5), .DEPTH(16), .NUM_BUFS(3), .CLEAR_VAL(4'h6)) u3 (
    .clk(clk), .rst(rst), .ce(ce), .swap(swap3), .vsync(vsync3), .wr_en(wr_en3),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready3), .rd_addr(rd_addr),
    .rd_data(rd_data3), .swap_pending(swap_pending3), .swap_done(swap_done3),
    .clear_busy(clear_busy3)
  );

  always @(negedge clk) if (!wr_ready3) u3_low_seen <= 1'b1;

  function automatic logic [3:0] pat(input logic [3:0] key, input int a);
    logic [31:0] av;
    av = a;
    return key ^ av[3:0];
  endfunction

  function automatic logic [31:0] roles_val(input int f, input int b, input int s, input int v);
    logic [31:0] fv, bv, sv, vv;
    fv = f; bv = b; sv = s; vv = v;
    return {25'd0, fv[1:0], bv[1:0], sv[1:0], vv[0]};
  endfunction

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic fill2(input logic [3:0] key);
    for (int i = 0; i < 16; i++) begin
      wr_en2 = 1'b1; wr_addr = 5'(i); wr_data = pat(key, i);
      applyStimulus(1);
    end
    wr_en2 = 1'b0;
  endtask

  task automatic fill3(input logic [3:0] key);
    for (int i = 0; i < 16; i++) begin
      wr_en3 = 1'b1; wr_addr = 5'(i); wr_data = pat(key, i);
      applyStimulus(1);
    end
    wr_en3 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ce = 1'b1;
    swap2 = 1'b0; vsync2 = 1'b0; wr_en2 = 1'b0;
    swap3 = 1'b0; vsync3 = 1'b0; wr_en3 = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    applyStimulus(2);
    checkOutput("rst_wr_ready2", 32'(wr_ready2), 1);
    checkOutput("rst_rd_data2", 32'(rd_data2), 0);
    checkOutput("rst_swap_done2", 32'(swap_done2), 0);
    checkOutput("rst_clear_busy2", 32'(clear_busy2), 0);
    checkOutput("rst_pending2", 32'(swap_pending2), 0);
    checkOutput("rst_wr_ready3", 32'(wr_ready3), 1);
    checkOutput("rst_pending3", 32'(swap_pending3), 0);
    checkOutput("rst_rd_data3", 32'(rd_data3), 0);
    checkOutput("rst_clear_busy3", 32'(clear_busy3), 0);
    checkOutput("rst_roles3", 32'(u3.roles), roles_val(0, 1, 2, 0));
    rst = 1'b0;

`ifdef FB_CLEAR_EN
    fill2(4'hA);
    swap2 = 1'b1; applyStimulus(1); swap2 = 1'b0;
    vsync2 = 1'b1; applyStimulus(1); vsync2 = 1'b0;
    checkOutput("clr_start_busy", 32'(clear_busy2), 1);
    checkOutput("clr_start_wr_ready", 32'(wr_ready2), 0);
    checkOutput("clr_start_done", 32'(swap_done2), 1);
    wr_en2 = 1'b1; wr_addr = 5'd2; wr_data = 4'hF; swap2 = 1'b1;
    for (int k = 1; k < 16; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("clr_busy_%0d", k), 32'(clear_busy2), 1);
    end
    wr_en2 = 1'b0; swap2 = 1'b0;
    applyStimulus(1);
    checkOutput("clr_end_busy", 32'(clear_busy2), 0);
    checkOutput("clr_end_wr_ready", 32'(wr_ready2), 1);
    checkOutput("clr_swap_ignored", 32'(swap_pending2), 0);
    swap2 = 1'b1; applyStimulus(1); swap2 = 1'b0;
    checkOutput("clr_pending", 32'(swap_pending2), 1);
    vsync2 = 1'b1; applyStimulus(1); vsync2 = 1'b0;
    applyStimulus(1);
    foreach (pat_addr_list[j]) begin
      rd_addr = pat_addr_list[j];
      applyStimulus(1);
      checkOutput($sformatf("clr_read_%0d", pat_addr_list[j]), 32'(rd_data2), 32'h6);
    end
`else
    // 2-bank: first frame, deferred swap with 5 pending cycles.
    fill2(4'hA);
    wr_en2 = 1'b1; wr_addr = 5'd20; wr_data = 4'hF;
    applyStimulus(1);
    wr_en2 = 1'b0;
    swap2 = 1'b1; applyStimulus(1); swap2 = 1'b0;
    wr_en2 = 1'b1; wr_addr = 5'd3; wr_data = 4'h0;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("pend_%0d", k), 32'(swap_pending2), 1);
      checkOutput($sformatf("pend_wr_ready_%0d", k), 32'(wr_ready2), 0);
      checkOutput($sformatf("pend_done_%0d", k), 32'(swap_done2), 0);
      if (k != 4) applyStimulus(1);
    end
    wr_en2 = 1'b0;
    vsync2 = 1'b1; applyStimulus(1); vsync2 = 1'b0;
    checkOutput("vs1_done", 32'(swap_done2), 1);
    checkOutput("vs1_pending", 32'(swap_pending2), 0);
    checkOutput("vs1_wr_ready", 32'(wr_ready2), 1);
    checkOutput("vs1_clear_busy", 32'(clear_busy2), 0);
    applyStimulus(1);
    checkOutput("vs1_done_pulse", 32'(swap_done2), 0);
    foreach (addr_list[j]) begin
      rd_addr = addr_list[j];
      applyStimulus(1);
      checkOutput($sformatf("f1_read_%0d", addr_list[j]), 32'(rd_data2), 32'(pat(4'hA, int'(addr_list[j]))));
    end
    rd_addr = 5'd20;
    applyStimulus(1);
    checkOutput("f1_read_oob", 32'(rd_data2), 0);

    // 2-bank: second frame, read issued in the switch cycle comes from the old bank.
    fill2(4'h5);
    swap2 = 1'b1; applyStimulus(1); swap2 = 1'b0;
    applyStimulus(3);
    vsync2 = 1'b1; rd_addr = 5'd5; applyStimulus(1); vsync2 = 1'b0; rd_addr = 5'd6;
    checkOutput("lat_old_bank", 32'(rd_data2), 32'(pat(4'hA, 5)));
    checkOutput("lat_done", 32'(swap_done2), 1);
    applyStimulus(1);
    checkOutput("lat_new_bank", 32'(rd_data2), 32'(pat(4'h5, 6)));

    // 2-bank: swap and vsync together only latch the swap.
    swap2 = 1'b1; vsync2 = 1'b1; applyStimulus(1); swap2 = 1'b0; vsync2 = 1'b0;
    checkOutput("same_pending", 32'(swap_pending2), 1);
    checkOutput("same_no_done", 32'(swap_done2), 0);
    applyStimulus(2);
    checkOutput("same_still_pending", 32'(swap_pending2), 1);
    rd_addr = 5'd7; vsync2 = 1'b1; applyStimulus(1); vsync2 = 1'b0;
    checkOutput("same_done", 32'(swap_done2), 1);
    checkOutput("same_cleared", 32'(swap_pending2), 0);
    checkOutput("same_old_read", 32'(rd_data2), 32'(pat(4'h5, 7)));
    applyStimulus(1);
    checkOutput("same_done_once", 32'(swap_done2), 0);
    checkOutput("same_new_read", 32'(rd_data2), 32'(pat(4'hA, 7)));

    // 2-bank: clock enable low freezes a pending swap.
    swap2 = 1'b1; applyStimulus(1); swap2 = 1'b0;
    checkOutput("ce_pending_set", 32'(swap_pending2), 1);
    ce = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vsync2 = (k % 2 == 0); swap2 = 1'b1;
      applyStimulus(1);
    end
    vsync2 = 1'b0; swap2 = 1'b0;
    checkOutput("ce_pending_hold", 32'(swap_pending2), 1);
    checkOutput("ce_no_done", 32'(swap_done2), 0);
    checkOutput("ce_wr_ready_hold", 32'(wr_ready2), 0);
    ce = 1'b1;

    // Reset mid-pending restores roles; RAM contents survive.
    rst = 1'b1; applyStimulus(1); rst = 1'b0;
    checkOutput("rst2_pending", 32'(swap_pending2), 0);
    checkOutput("rst2_wr_ready", 32'(wr_ready2), 1);
    checkOutput("rst2_done", 32'(swap_done2), 0);
    checkOutput("rst2_rd_data", 32'(rd_data2), 0);
    rd_addr = 5'd6; applyStimulus(1);
    checkOutput("rst2_front0", 32'(rd_data2), 32'(pat(4'h5, 6)));
    wr_en2 = 1'b1; wr_addr = 5'd9; wr_data = 4'h0; applyStimulus(1); wr_en2 = 1'b0;
    swap2 = 1'b1; applyStimulus(1); swap2 = 1'b0;
    vsync2 = 1'b1; rd_addr = 5'd9; applyStimulus(1); vsync2 = 1'b0;
    applyStimulus(1);
    checkOutput("rst2_back1", 32'(rd_data2), 0);

    // 3-bank: two swaps before vsync drop the older frame; writer never stalls.
    u3_low_seen = 1'b0;
    fill3(4'hA);
    swap3 = 1'b1; applyStimulus(1); swap3 = 1'b0;
    checkOutput("t3_ready_vld", 32'(swap_pending3), 1);
    checkOutput("t3_roles_swap1", 32'(u3.roles), roles_val(0, 2, 1, 1));
    fill3(4'h5);
    swap3 = 1'b1; applyStimulus(1); swap3 = 1'b0;
    checkOutput("t3_roles_swap2", 32'(u3.roles), roles_val(0, 1, 2, 1));
    checkOutput("t3_no_done", 32'(swap_done3), 0);
    vsync3 = 1'b1; applyStimulus(1); vsync3 = 1'b0;
    checkOutput("t3_done", 32'(swap_done3), 1);
    checkOutput("t3_ready_clr", 32'(swap_pending3), 0);
    checkOutput("t3_roles_vs", 32'(u3.roles), roles_val(2, 1, 0, 0));
    checkOutput("t3_distinct", 32'(u3.roles.front != u3.roles.back && u3.roles.back != u3.roles.spare
                                    && u3.roles.front != u3.roles.spare), 1);
    rd_addr = 5'd6; applyStimulus(1);
    checkOutput("t3_read_6", 32'(rd_data3), 32'(pat(4'h5, 6)));
    rd_addr = 5'd1; applyStimulus(1);
    checkOutput("t3_read_1", 32'(rd_data3), 32'(pat(4'h5, 1)));
    swap3 = 1'b1; applyStimulus(1); swap3 = 1'b0;
    checkOutput("t3_roles_swap3", 32'(u3.roles), roles_val(2, 0, 1, 1));
    swap3 = 1'b1; vsync3 = 1'b1; applyStimulus(1); swap3 = 1'b0; vsync3 = 1'b0;
    checkOutput("t3_roles_both", 32'(u3.roles), roles_val(1, 2, 0, 1));
    checkOutput("t3_both_done", 32'(swap_done3), 1);
    vsync3 = 1'b1; applyStimulus(1); vsync3 = 1'b0;
    checkOutput("t3_roles_vs2", 32'(u3.roles), roles_val(0, 2, 1, 0));
    checkOutput("t3_wr_ready_never_low", 32'(u3_low_seen), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  logic [4:0] addr_list [4] = '{5'd0, 5'd3, 5'd4, 5'd15};
  logic [4:0] pat_addr_list [3] = '{5'd0, 5'd2, 5'd15};

endmodule
